// File: rtl/m_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_mem_ctrl_pkg
// Description : Shared CPU constants for the M-stage memory controller.
//               Holds the memOp encodings, the FSM state encoding, the bus
//               timeout constant and small op-decoding helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package m_mem_ctrl_pkg;

    // M-stage memory operation encodings; 9-15 decode as "no access"
    localparam logic [3:0] c_op_none = 4'd0;
    localparam logic [3:0] c_op_lw   = 4'd1;
    localparam logic [3:0] c_op_lh   = 4'd2;
    localparam logic [3:0] c_op_lhu  = 4'd3;
    localparam logic [3:0] c_op_lb   = 4'd4;
    localparam logic [3:0] c_op_lbu  = 4'd5;
    localparam logic [3:0] c_op_sw   = 4'd6;
    localparam logic [3:0] c_op_sh   = 4'd7;
    localparam logic [3:0] c_op_sb   = 4'd8;

    // Number of REQ cycles allowed without an ack before the access aborts
    localparam logic [7:0] c_timeout_cycles = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for any real load or store (1-8)
    function automatic logic op_is_access(input logic [3:0] op);
        return (op >= c_op_lw) && (op <= c_op_sb);
    endfunction

    // True for sw/sh/sb
    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= c_op_sw) && (op <= c_op_sb);
    endfunction

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0
    function automatic logic op_misaligned(input logic [3:0] op,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            c_op_lw, c_op_sw:           mis = (addr_lo != 2'b00);
            c_op_lh, c_op_lhu, c_op_sh: mis = addr_lo[0];
            default:                    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_mem_ctrl_ldext.sv
`default_nettype none
// ============================================================================
// Module      : m_ldext
// Description : Load extension. Selects the addressed byte/halfword of a bus
//               read word and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ldext
    import m_mem_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane select, then extend according to the load flavour
    always_comb begin
        w_half = addr_lo[1] ? word[31:16] : word[15:0];
        case (addr_lo)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        case (op)
            c_op_lh:  data = {{16{w_half[15]}}, w_half};
            c_op_lhu: data = {16'h0000, w_half};
            c_op_lb:  data = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: data = {24'h000000, w_byte};
            default:  data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : m_mem_ctrl
// Description : M-stage memory controller. Captures one load/store, runs a
//               req/ack bus handshake with a 255-cycle timeout, stalls the
//               pipeline while the access is outstanding and returns an
//               extended load result with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module m_mem_ctrl
    import m_mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  memOp,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_byteen,
    input  logic [31:0] data_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        m_stall,
    output logic [31:0] m_rdata,
    output logic        m_done,
    output logic        m_err
);

    state_e      state_q,  state_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [3:0]  op_q,     op_d;
    logic [31:0] addr_q,   addr_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic [31:0] w_ld_data;

    // Extension runs on the live bus word; the result is latched on ack
    m_ldext u_ldext (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (mem_rdata),
        .data    (w_ld_data)
    );

    // State register and captured access fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            op_q     <= c_op_none;
            addr_q   <= 32'd0;
            byteen_q <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: capture in IDLE, handshake/timeout in REQ, pulse in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (op_is_access(memOp)) begin
                    op_d     = memOp;
                    addr_d   = data_addr;
                    // Loads present zero enables/data on the bus
                    byteen_d = op_is_store(memOp) ? data_byteen : 4'd0;
                    wdata_d  = op_is_store(memOp) ? data_wdata  : 32'd0;
                    cnt_d    = 8'd0;
                    if (op_misaligned(memOp, data_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the final allowed cycle still wins over timeout
                if (mem_ack) begin
                    rdata_d = op_is_store(op_q) ? 32'd0 : w_ld_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == (c_timeout_cycles - 8'd1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and pipeline outputs; bus fields are forced to zero outside REQ
    always_comb begin
        mem_req    = (state_q == ST_REQ);
        mem_we     = mem_req && op_is_store(op_q);
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_byteen = mem_req ? byteen_q : 4'd0;
        mem_wdata  = mem_req ? wdata_q  : 32'd0;
        m_stall    = ((state_q == ST_IDLE) && op_is_access(memOp)) || mem_req;
        m_done     = (state_q == ST_DONE);
        m_rdata    = rdata_q;
        m_err      = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_m_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_mem_ctrl
// Description : Scoreboard bench for m_mem_ctrl. The stimulus pushes the
//               expected {err, rdata} of each access; a monitor pops and
//               compares on every m_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_mem_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  memOp;
    logic [31:0] data_addr;
    logic [3:0]  data_byteen;
    logic [31:0] data_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        m_stall;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb_q[$];

    m_mem_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .memOp       (memOp),
        .data_addr   (data_addr),
        .data_byteen (data_byteen),
        .data_wdata  (data_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_byteen  (mem_byteen),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .m_stall     (m_stall),
        .m_rdata     (m_rdata),
        .m_done      (m_done),
        .m_err       (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (m_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("m_rdata", m_rdata, exp[31:0]);
                    chk("m_err", {31'd0, m_err}, {31'd0, exp[32]});
                end
            end
        end
    end

    // Issue one access and act as the bus; ack_at is the REQ cycle index
    // (0 = first) in which to ack, or -1 for never
    task automatic access(input logic [3:0] op, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_stall, input int exp_req);
        int  stall_n;
        int  req_n;
        int  cyc;
        logic done_seen;
        logic is_st;
        is_st = (op >= 4'd6) && (op <= 4'd8);
        stall_n = 0; req_n = 0; cyc = 0; done_seen = 1'b0;
        @(negedge clk);
        memOp = op; data_addr = addr; data_byteen = be; data_wdata = wd;
        sb_q.push_back({exp_err, exp_data});
        while (!done_seen && cyc < 400) begin
            #1;
            if (m_stall) stall_n++;
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
            if (mem_req) begin
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_we", {31'd0, mem_we}, {31'd0, is_st});
                chk("mem_byteen", {28'd0, mem_byteen}, is_st ? {28'd0, be} : 32'd0);
                chk("mem_wdata", mem_wdata, is_st ? wd : 32'd0);
                if (req_n == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                req_n++;
            end
            if (m_done) begin
                done_seen = 1'b1;
                chk("stall_in_done", {31'd0, m_stall}, 32'd0);
                memOp = 4'd0;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            cyc++;
        end
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("stall_cycles", stall_n, exp_stall);
        chk("req_cycles", req_n, exp_req);
    endtask

    initial begin
        reset = 1'b1; memOp = 4'd0; data_addr = 32'd0; data_byteen = 4'd0;
        data_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_m_stall", {31'd0, m_stall}, 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_m_done", {31'd0, m_done}, 32'd0);
        chk("rst_m_err", {31'd0, m_err}, 32'd0);
        reset = 1'b0;

        // op, addr, be, wdata, ack_at, rdata, exp_data, exp_err, stall, req
        access(4'd1, 32'h10, 4'h0, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1);
        access(4'd4, 32'h13, 4'h0, 32'h0, 0, 32'h80FF7F01, 32'hFFFFFF80, 1'b0, 2, 1);
        access(4'd5, 32'h13, 4'h0, 32'h0, 0, 32'h80FF7F01, 32'h00000080, 1'b0, 2, 1);
        access(4'd4, 32'h11, 4'h0, 32'h0, 1, 32'h80FF7F01, 32'h0000007F, 1'b0, 3, 2);
        access(4'd2, 32'h12, 4'h0, 32'h0, 0, 32'h80FF7F01, 32'hFFFF80FF, 1'b0, 2, 1);
        access(4'd3, 32'h12, 4'h0, 32'h0, 3, 32'h80FF7F01, 32'h000080FF, 1'b0, 5, 4);
        access(4'd2, 32'h30, 4'h0, 32'h0, 0, 32'h12347FFF, 32'h00007FFF, 1'b0, 2, 1);
        access(4'd7, 32'h22, 4'hC, 32'hABCD0000, 0, 32'h55555555, 32'h0, 1'b0, 2, 1);
        access(4'd6, 32'h44, 4'hF, 32'h01020304, 2, 32'h55555555, 32'h0, 1'b0, 4, 3);
        access(4'd1, 32'h11, 4'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1, 1, 0);
        access(4'd7, 32'h23, 4'h3, 32'h0000BEEF, 0, 32'h0, 32'h0, 1'b1, 1, 0);
        access(4'd1, 32'h40, 4'h0, 32'h0, -1, 32'h0, 32'h0, 1'b1, 256, 255);
        access(4'd1, 32'h48, 4'h0, 32'h0, 254, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 256, 255);

        // Reserved op: no access, no stall
        @(negedge clk);
        memOp = 4'd9;
        #1;
        chk("op9_stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("op9_req", {31'd0, mem_req}, 32'd0);
        memOp = 4'd0;

        // Reset while in REQ, then a stray ack
        @(negedge clk);
        memOp = 4'd1; data_addr = 32'h80;
        @(negedge clk);
        #1;
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        memOp = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) begin
            #1;
            chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
            chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
            chk("abort_mem_addr", mem_addr, 32'd0);
            chk("abort_mem_byteen", {28'd0, mem_byteen}, 32'd0);
            chk("abort_mem_wdata", mem_wdata, 32'd0);
            chk("abort_m_stall", {31'd0, m_stall}, 32'd0);
            chk("abort_m_rdata", m_rdata, 32'd0);
            chk("abort_m_done", {31'd0, m_done}, 32'd0);
            chk("abort_m_err", {31'd0, m_err}, 32'd0);
            @(negedge clk);
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
